// File: rtl/rdcla_pkg.sv
// Shared definitions for the borrow-lookahead network: KPG encoding,
// merge/init helpers and default datapath sizes.
package rdcla_pkg;

    localparam int RDCLA_WIDTH = 32;
    localparam int RDCLA_LOG2W = 5;

    typedef logic [1:0] kpg_t;

    localparam kpg_t KPG_KILL = 2'b00;
    localparam kpg_t KPG_GEN  = 2'b11;
    localparam kpg_t KPG_PROP = 2'b10;

    // Combine a position with the group just below it: kill/generate
    // decide on their own, propagate defers to the lower group.
    function automatic kpg_t kpg_merge(input kpg_t cur, input kpg_t prev);
        return (cur == KPG_PROP) ? prev : cur;
    endfunction

    // Classify one bit column from its two addend bits.
    function automatic kpg_t kpg_init(input logic x, input logic y);
        if (x && y) begin
            return KPG_GEN;
        end else if (!x && !y) begin
            return KPG_KILL;
        end
        return KPG_PROP;
    endfunction

endpackage

// File: rtl/rdcla_sub_pipe_if.sv
// Operand/result bundle of the pipelined subtractor.
interface rdcla_sub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, flush,
        input  out_valid, diff, bout, zero, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, flush,
        output out_valid, diff, bout, zero, ovf
    );
endinterface

// File: rtl/kpg_merge_cell.sv
// One position of a doubling stage: merge a KPG group with the group
// span positions below it.
module kpg_merge_cell
    import rdcla_pkg::*;
(
    input  kpg_t cur,
    input  kpg_t prev,
    output kpg_t res
);
    assign res = kpg_merge(cur, prev);
endmodule

// File: rtl/rdcla_sub_pipe.sv
// Pipelined recursive-doubling borrow-lookahead subtractor:
// diff = a - b - bin computed as a + ~b + ~bin. Operands and valid travel
// beside the carry network so results, flags and valid leave aligned.
module rdcla_sub_pipe
    import rdcla_pkg::*;
#(
    parameter int WIDTH = RDCLA_WIDTH,
    parameter int LOG2W = RDCLA_LOG2W
) (
    input logic             clk,
    input logic             rst_n,
    rdcla_sub_pipe_if.slave bus
);

    // Stage p0: operand capture
    logic             vld_p0;
    logic             bin_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;

    // Register the incoming operands; flush drops the operand arriving with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            bin_p0 <= 1'b0;
            a_p0   <= '0;
            b_p0   <= '0;
        end else begin
            vld_p0 <= bus.in_valid & ~bus.flush;
            bin_p0 <= bus.bin;
            a_p0   <= bus.a;
            b_p0   <= bus.b;
        end
    end

    // Stage p1: KPG initialisation
    kpg_t init_kpg [0:WIDTH];

    // Position 0 is the injected carry ~bin. Position 1 already folds bit 0
    // with that carry, so the top position (whose span after LOG2W stages
    // reaches down only to position 1) still resolves when every bit propagates.
    always_comb begin
        init_kpg[0] = bin_p0 ? KPG_KILL : KPG_GEN;
        init_kpg[1] = kpg_merge(kpg_init(a_p0[0], ~b_p0[0]),
                                bin_p0 ? KPG_KILL : KPG_GEN);
        for (int i = 1; i < WIDTH; i++) begin
            init_kpg[i+1] = kpg_init(a_p0[i], ~b_p0[i]);
        end
    end

    // Stages 1..LOG2W: doubling network
    kpg_t             net    [0:LOG2W][0:WIDTH];
    kpg_t             merged [1:LOG2W][0:WIDTH];
    logic [WIDTH-1:0] a_sr   [0:LOG2W];
    logic [WIDTH-1:0] nb_sr  [0:LOG2W];
    logic [LOG2W:0]   vld_sr;

    for (genvar s = 1; s <= LOG2W; s++) begin : g_stage
        localparam int SPAN = 1 << (s - 1);
        for (genvar j = 0; j <= WIDTH; j++) begin : g_pos
            if (j >= SPAN) begin : g_merge
                kpg_merge_cell u_cell (
                    .cur  (net[s-1][j]),
                    .prev (net[s-1][j-SPAN]),
                    .res  (merged[s][j])
                );
            end else begin : g_pass
                assign merged[s][j] = net[s-1][j];
            end
        end
    end

    // Advance the KPG network one doubling per stage with operands and valid alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
            for (int s = 0; s <= LOG2W; s++) begin
                a_sr[s]  <= '0;
                nb_sr[s] <= '0;
                for (int j = 0; j <= WIDTH; j++) begin
                    net[s][j] <= KPG_KILL;
                end
            end
        end else begin
            vld_sr   <= bus.flush ? '0 : {vld_sr[LOG2W-1:0], vld_p0};
            a_sr[0]  <= a_p0;
            nb_sr[0] <= ~b_p0;
            for (int j = 0; j <= WIDTH; j++) begin
                net[0][j] <= init_kpg[j];
            end
            for (int s = 1; s <= LOG2W; s++) begin
                a_sr[s]  <= a_sr[s-1];
                nb_sr[s] <= nb_sr[s-1];
                for (int j = 0; j <= WIDTH; j++) begin
                    net[s][j] <= merged[s][j];
                end
            end
        end
    end

    // Output stage
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diff_c;
    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             zero_q;
    logic             ovf_q;

    // Carry into bit i is the generate bit of resolved position i.
    always_comb begin
        carry = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            carry[i] = net[LOG2W][i][0];
        end
    end

    assign diff_c = a_sr[LOG2W] ^ nb_sr[LOG2W] ^ carry[WIDTH-1:0];

    // Register result and flags; they hold their last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= vld_sr[LOG2W] & ~bus.flush;
            if (vld_sr[LOG2W] && !bus.flush) begin
                diff_q <= diff_c;
                bout_q <= ~carry[WIDTH];
                zero_q <= (diff_c == '0);
                // nb sign equal to a sign means a and b differ in sign.
                ovf_q  <= (a_sr[LOG2W][WIDTH-1] == nb_sr[LOG2W][WIDTH-1]) &&
                          (diff_c[WIDTH-1] != a_sr[LOG2W][WIDTH-1]);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;

    // Every position must be resolved to kill/generate after the last doubling stage.
    always @(posedge clk) begin
        if (rst_n && vld_sr[LOG2W]) begin
            for (int i = 0; i <= WIDTH; i++) begin
                assert (net[LOG2W][i] != KPG_PROP);
            end
        end
    end

endmodule

// File: tb/tb_rdcla_sub_pipe.sv
// Directed and streaming bench for rdcla_sub_pipe with a queue scoreboard.
module tb_rdcla_sub_pipe;

    localparam int W   = 32;
    localparam int LAT = 7;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
        int           issue;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_in  = 0;
    int   n_out = 0;
    exp_t sb[$];

    rdcla_sub_pipe_if #(.WIDTH(W)) bus ();

    rdcla_sub_pipe #(.WIDTH(W), .LOG2W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference: wide unsigned subtraction for diff/borrow, wide signed for overflow.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t       e;
        logic [W:0] w;
        longint     sr;
        w  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        e.diff  = w[W-1:0];
        e.bout  = w[W];
        e.zero  = (w[W-1:0] == '0);
        e.ovf   = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
        e.issue = 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (rst_n && bus.out_valid) begin
            n_out++;
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_out_valid observed=1 expected=0");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("diff", bus.diff, e.diff);
                check("bout", bus.bout, e.bout);
                check("zero", bus.zero, e.zero);
                check("ovf", bus.ovf, e.ovf);
                check("latency", cyc - e.issue, LAT);
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                         input logic tbin, input logic fl, input exp_t e);
        exp_t ee;
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = ta;
        bus.b        = tbv;
        bus.bin      = tbin;
        bus.flush    = fl;
        if (fl) begin
            sb.delete();
        end else if (v) begin
            ee       = e;
            ee.issue = cyc + 1;
            sb.push_back(ee);
            n_in++;
        end
    endtask

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tbin);
        drive(1'b1, ta, tbv, tbin, 1'b0, model(ta, tbv, tbin));
    endtask

    task automatic op_exp(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tbin,
                          input logic [W-1:0] d, input logic bo, input logic z, input logic ov);
        exp_t e;
        e.diff  = d;
        e.bout  = bo;
        e.zero  = z;
        e.ovf   = ov;
        e.issue = 0;
        drive(1'b1, ta, tbv, tbin, 1'b0, e);
    endtask

    task automatic idle();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        ra = $urandom;
        rb = $urandom;
        drive(1'b0, ra, rb, 1'b1, 1'b0, model(ra, rb, 1'b1));
    endtask

    task automatic drain();
        for (int k = 0; k < 3 * LAT && sb.size() != 0; k++) idle();
        check("drain_empty", sb.size(), 0);
        for (int k = 0; k < LAT + 2; k++) idle();
    endtask

    initial begin
        int in0;
        int out0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.bin      = 1'b0;
        bus.flush    = 1'b0;

        // Held in reset with toggling in_valid: outputs stay cleared.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            bus.a        = $urandom;
            bus.b        = $urandom;
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_diff", bus.diff, 0);
            check("rst_bout", bus.bout, 0);
            check("rst_zero", bus.zero, 0);
            check("rst_ovf", bus.ovf, 0);
        end
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;

        op_exp(32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
        drain();

        // Directed boundary cases, back to back.
        op_exp(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        op_exp(32'h8000_0000, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        op_exp(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        op_exp(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        op_exp(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        op_exp(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        drain();

        // Streaming with random bubbles.
        in0  = n_in;
        out0 = n_out;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                ra = $urandom;
                rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
                op(ra, rb, 1'($urandom_range(0, 1)));
            end
        end
        drain();
        check("stream_count", n_out - out0, n_in - in0);

        // Flush three cycles after the first of four ops; the next op survives.
        out0 = n_out;
        for (int i = 0; i < 3; i++) op($urandom, $urandom, 1'b0);
        ra = $urandom;
        rb = $urandom;
        drive(1'b1, ra, rb, 1'b0, 1'b1, model(ra, rb, 1'b0));
        op(32'h1234_5678, 32'h0000_1111, 1'b1);
        drain();
        check("flush_count", n_out - out0, 1);

        // One-cycle reset pulse mid-stream discards everything in flight.
        out0 = n_out;
        for (int i = 0; i < 3; i++) op($urandom, $urandom, 1'b0);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op(32'h0000_0010, 32'h0000_0020, 1'b0);
        drain();
        check("midrst_count", n_out - out0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rdcla_sub_pipe.md
Name: rdcla_sub_pipe

Overview:
- Pipelined 32-bit recursive-doubling borrow-lookahead subtractor for the pipelined FP datapath.
- Main uses: exponent-difference computation and effective-subtraction mantissa path.
- Computes diff = a - b - bin as a + ~b + ~bin, using the kill/propagate/generate doubling network.
- Carries operands and a valid bit alongside the carry network, so diff, flags and valid leave the pipeline aligned.
- One result per clock, no backpressure.

Parameters:
- WIDTH, 32: operand width; must be a power of two ≥ 2.
- LOG2W, 5: log2(WIDTH); number of doubling stages (spans 1, 2, 4, 8, 16).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a/b/bin are valid this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in (1 = subtract an extra 1).
- flush  input  1  synchronous: clears every valid bit in the pipeline.
- out_valid  output  1  diff/flags valid.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when unsigned a < b + bin.
- zero  output  1  diff == 0.
- ovf  output  1  signed two's-complement overflow of the subtraction.

Behaviour:
- Clock and reset:
  - One clock (clk); reset rst_n is asynchronous and active-low.
  - While rst_n = 0: every pipeline register, including all valid bits and all outputs, is 0 (out_valid=0, diff=0, bout=0, zero=0, ovf=0).
  - Release is synchronous to the next rising edge.
- KPG encoding (2-bit {c1,c0}): kill=00, generate=11, propagate=10; 01 never produced.
- Stage 0 (init), registered:
  - bit i from a[i] and nb[i] = ~b[i]: 00→kill, 11→gen, else prop.
  - Position 0 carries the injected carry ~bin (gen if bin=0, kill if bin=1).
  - Also registers a, nb, in_valid.
- Stages 1..LOG2W, registered: stage s with span d = 2^(s-1).
  - For position j ≥ d: out[j] = merge(cur[j], prev[j-d]).
  - merge: kill/gen pass cur; prop takes prev.
  - Positions j < d pass through unchanged.
  - a, nb, valid ride along in shift registers.
- Output register (after stage LOG2W):
  - carry[i] = c0 of resolved position i.
  - diff = a ^ nb ^ carry[WIDTH-1:0].
  - bout = ~carry[WIDTH].
  - zero = (diff == 0).
  - ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]).
  - Every network position is fully resolved to kill/gen after LOG2W stages; assertion: no prop remains.
- Latency: in_valid sampled at edge n → out_valid=1 with matching result after edge n+LOG2W+2 (7 cycles at WIDTH=32).
- Throughput: one operation per cycle; back-to-back inputs produce back-to-back outputs in order.
- Bubbles: in_valid=0 cycles propagate as out_valid=0. Data registers still load (don't-care) and must not disturb valid slots.
- flush: when high at an edge, all valid bits load 0, including the one entering from in_valid that cycle. Operands entering the edge after flush deasserts are unaffected.
- Reset mid-operation: all in-flight results are discarded; no out_valid pulse may appear for pre-reset inputs.
- When out_valid=0, outputs hold their last values; the bench must ignore them.

Decomposition:
- Shared package rdcla_pkg holds:
  - KPG_KILL=2'b00, KPG_GEN=2'b11, KPG_PROP=2'b10;
  - kpg_t 2-bit typedef;
  - function kpg_merge(cur, prev);
  - default WIDTH/LOG2W constants. The fp adder pipe reuses these.
- One sub-module, kpg_merge_cell: combinational merge of one position. It is instantiated as arrays per stage, with a register slice in the parent.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 toggling → out_valid=0, diff=0, bout=0 throughout. Deassert, then a=5, b=3, bin=0 → 7 cycles later diff=2, bout=0, zero=0, ovf=0.
- Borrow and full chain: a=0, b=1, bin=0 → diff=0xFFFFFFFF, bout=1, ovf=0. Then a=0x80000000, b=0x80000000, bin=1 → diff=0xFFFFFFFF, bout=1.
- Signed overflow: a=0x80000000, b=1 → diff=0x7FFFFFFF, ovf=1, bout=0. a=0x7FFFFFFF, b=0xFFFFFFFF → diff=0x80000000, ovf=1, bout=1.
- Zero flag: a=b=0xDEADBEEF, bin=0 → diff=0, zero=1, bout=0. Same operands with bin=1 → diff=0xFFFFFFFF, zero=0, bout=1.
- Streaming: 1000 random back-to-back ops with random in_valid bubbles → outputs match the reference model in order, each exactly 7 cycles after input. Count of out_valid equals count of in_valid.
- Flush and reset mid-flight: issue 4 ops, assert flush 3 cycles after the first → no out_valid for those 4. Op issued the cycle after flush → appears normally. Repeat with rst_n pulse low for 1 cycle mid-stream → zero stale outputs.
